// File: rtl/clk_en_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_pkg
// Shared types and helpers for the multi-channel clock-enable generator.
//   clk_en_mode_e     : channel output mode (pulse strobe or square toggle)
//   CLK_EN_CNT_WIDTH  : default width of divisor and per-channel counter
//   clk_en_ch_width() : width of a channel index (never less than 1 bit)
// -----------------------------------------------------------------------------
package clk_en_pkg;

   typedef enum logic {
      CLK_EN_PULSE  = 1'b0,
      CLK_EN_TOGGLE = 1'b1
   } clk_en_mode_e;

   localparam int CLK_EN_CNT_WIDTH = 16;

   function automatic int clk_en_ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage : clk_en_pkg

// File: rtl/clk_en_channel.sv
// -----------------------------------------------------------------------------
// clk_en_channel
// One channel of the clock-enable generator: period counter, active
// divisor/mode, a one-deep pending update and the registered output.
// A pending update is applied at the period boundary (counter wrap) while
// running, or on the next edge while stopped.
//
// Optional feature macro: CLK_EN_PHASE_EN adds a start phase that is loaded
// into the counter on apply and whenever the channel is stopped.
//
// Ports
//   in_clk    : clock
//   reset_n   : asynchronous active-low reset
//   run       : channel running (global enable AND channel enable)
//   wr_en     : store a legal update (only asserted while not pending)
//   wr_div    : new divisor (non-zero)
//   wr_mode   : new output mode
//   wr_phase  : new start phase (CLK_EN_PHASE_EN only)
//   pending   : an update is stored and not yet applied
//   clk_en    : registered clock-enable output
// -----------------------------------------------------------------------------
module clk_en_channel
   import clk_en_pkg::*;
#(
   parameter int CNT_WIDTH   = CLK_EN_CNT_WIDTH,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                 in_clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 wr_en,
   input  logic [CNT_WIDTH-1:0] wr_div,
   input  clk_en_mode_e         wr_mode,
`ifdef CLK_EN_PHASE_EN
   input  logic [CNT_WIDTH-1:0] wr_phase,
`endif
   output logic                 pending,
   output logic                 clk_en
);

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] div;
   logic [CNT_WIDTH-1:0] new_div;
   clk_en_mode_e         mode;
   clk_en_mode_e         new_mode;

   logic                 wrap;
   logic                 apply;
   logic [CNT_WIDTH-1:0] stop_cnt;   // counter value while stopped
   logic [CNT_WIDTH-1:0] wrap_cnt;   // counter value after a wrap

`ifdef CLK_EN_PHASE_EN
   logic [CNT_WIDTH-1:0] phase;
   logic [CNT_WIDTH-1:0] new_phase;
`endif

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      wrap  = (cnt == div - 1'b1);
      apply = pending && (!run || wrap);
`ifdef CLK_EN_PHASE_EN
      stop_cnt = apply ? new_phase : phase;
      wrap_cnt = apply ? new_phase : '0;
`else
      stop_cnt = '0;
      wrap_cnt = '0;
`endif
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         div       <= CNT_WIDTH'(DEFAULT_DIV);
         mode      <= CLK_EN_PULSE;
         new_div   <= CNT_WIDTH'(DEFAULT_DIV);
         new_mode  <= CLK_EN_PULSE;
         pending   <= 1'b0;
         clk_en    <= 1'b0;
`ifdef CLK_EN_PHASE_EN
         phase     <= '0;
         new_phase <= '0;
`endif
      end else begin
         // wr_en is gated by !pending upstream, so it never meets apply.
         if (wr_en) begin
            pending   <= 1'b1;
            new_div   <= wr_div;
            new_mode  <= wr_mode;
`ifdef CLK_EN_PHASE_EN
            new_phase <= wr_phase;
`endif
         end

         if (apply) begin
            pending <= 1'b0;
            div     <= new_div;
            mode    <= new_mode;
`ifdef CLK_EN_PHASE_EN
            phase   <= new_phase;
`endif
         end

         if (!run) begin
            cnt    <= stop_cnt;
            clk_en <= 1'b0;
         end else if (wrap) begin
            cnt <= wrap_cnt;
            // The closing edge of the old period still strobes in pulse
            // mode; a fresh toggle period always starts low.
            if (apply && new_mode == CLK_EN_TOGGLE)
               clk_en <= 1'b0;
            else if (mode == CLK_EN_PULSE)
               clk_en <= 1'b1;
            else
               clk_en <= !clk_en;
         end else begin
            cnt <= cnt + 1'b1;
            if (mode == CLK_EN_PULSE)
               clk_en <= 1'b0;
         end
      end
   end

endmodule : clk_en_channel

// File: rtl/clk_en_gen_multi.sv
// -----------------------------------------------------------------------------
// clk_en_gen_multi
// Multi-channel programmable clock-enable generator. Each channel emits a
// one-cycle strobe every div cycles (pulse mode) or a square enable that
// inverts every div cycles (toggle mode). Divisor and mode are updated via
// a valid/ready port; updates take effect at the channel's period boundary.
//
// Optional feature macro: CLK_EN_PHASE_EN adds cfg_phase, a start offset for
// the channel counter; requests with cfg_phase >= cfg_div are rejected.
//
// Ports
//   in_clk     : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : global run, low stops every channel
//   ch_en      : per-channel run
//   cfg_valid  : configuration request
//   cfg_ready  : target channel has no pending update
//   cfg_ch     : target channel index
//   cfg_div    : new divisor (0 is rejected)
//   cfg_mode   : 0 = pulse, 1 = toggle
//   cfg_phase  : start phase (CLK_EN_PHASE_EN only)
//   cfg_err    : one-cycle pulse after a rejected request
//   clk_en     : per-channel registered clock-enable
// -----------------------------------------------------------------------------
module clk_en_gen_multi
   import clk_en_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int CNT_WIDTH   = CLK_EN_CNT_WIDTH,
   parameter  int DEFAULT_DIV = 2,
   localparam int CH_W        = clk_en_ch_width(NUM_CH)
) (
   input  logic                 in_clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [CNT_WIDTH-1:0] cfg_div,
   input  logic                 cfg_mode,
`ifdef CLK_EN_PHASE_EN
   input  logic [CNT_WIDTH-1:0] cfg_phase,
`endif
   output logic                 cfg_err,
   output logic [NUM_CH-1:0]    clk_en
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] wr_en;
   logic              ch_ok;
   logic              req_bad;
   logic              accept;

   always_comb begin
      ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

      // Out-of-range indices stay ready so the request is taken and flagged.
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (cfg_ch == CH_W'(i))
            cfg_ready = !pending[i];

      accept  = cfg_valid && cfg_ready;
      req_bad = !ch_ok || (cfg_div == '0)
`ifdef CLK_EN_PHASE_EN
                || (cfg_phase >= cfg_div)
`endif
                ;

      wr_en = '0;
      for (int i = 0; i < NUM_CH; i++)
         wr_en[i] = accept && !req_bad && (cfg_ch == CH_W'(i));
   end

   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n)
         cfg_err <= 1'b0;
      else
         cfg_err <= accept && req_bad;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_en_channel #(
         .CNT_WIDTH   (CNT_WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .in_clk   (in_clk),
         .reset_n  (reset_n),
         .run      (enable && ch_en[g]),
         .wr_en    (wr_en[g]),
         .wr_div   (cfg_div),
         .wr_mode  (clk_en_mode_e'(cfg_mode)),
`ifdef CLK_EN_PHASE_EN
         .wr_phase (cfg_phase),
`endif
         .pending  (pending[g]),
         .clk_en   (clk_en[g])
      );
   end

endmodule : clk_en_gen_multi

// File: tb/tb_clk_en_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen_multi
// Directed bench for clk_en_gen_multi (NUM_CH = 4, CNT_WIDTH = 16,
// DEFAULT_DIV = 2). Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, i.e. they show what the last edge registered.
// -----------------------------------------------------------------------------
module tb_clk_en_gen_multi;

   logic        in_clk;
   logic        reset_n;
   logic        enable;
   logic [3:0]  ch_en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_div;
   logic        cfg_mode;
`ifdef CLK_EN_PHASE_EN
   logic [15:0] cfg_phase;
`endif
   logic        cfg_err;
   logic [3:0]  clk_en;

   int n_cmp = 0;
   int n_bad = 0;

   clk_en_gen_multi #(
      .NUM_CH      (4),
      .CNT_WIDTH   (16),
      .DEFAULT_DIV (2)
   ) dut (
      .in_clk    (in_clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
`ifdef CLK_EN_PHASE_EN
      .cfg_phase (cfg_phase),
`endif
      .cfg_err   (cfg_err),
      .clk_en    (clk_en)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic stop_all();
      ch_en = 4'b0000;
      step();
   endtask

   task automatic test_reset();
      repeat (2) step();
      n_cmp++;
      if (clk_en !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_clk_en: got %b want 0000", clk_en);
      end
      n_cmp++;
      if (cfg_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_cfg_err: got %b want 0", cfg_err);
      end
      for (int c = 0; c < 4; c++) begin
         cfg_ch = 2'(c);
         #1;
         n_cmp++;
         if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cfg_ready ch%0d: got %b want 1", c, cfg_ready);
         end
      end
      reset_n = 1'b1;
      step();
   endtask

   // ch0 at the reset divisor of 2: strobe on every second edge.
   task automatic test_default_div();
      logic [3:0] exp;
      enable = 1'b1;
      ch_en  = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         step();
         exp = (k % 2 == 1) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (clk_en !== exp) begin
            n_bad++;
            $display("FAIL default_div edge%0d: got %b want %b", k, clk_en, exp);
         end
      end
      // Global enable low freezes everything even with all ch_en set.
      enable = 1'b0;
      ch_en  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++;
         if (clk_en !== 4'b0000) begin
            n_bad++;
            $display("FAIL enable_off edge%0d: got %b want 0000", k, clk_en);
         end
      end
      enable = 1'b1;
   endtask

   // ch1 running at div 2; request div 5 toggle applies at its first wrap.
   task automatic test_toggle_cfg();
      logic [3:0] exp;
      stop_all();
      ch_en     = 4'b0010;
      cfg_valid = 1'b1;
      cfg_ch    = 2'd1;
      cfg_div   = 16'd5;
      cfg_mode  = 1'b1;
      step();                       // accept, cnt 0 -> 1
      cfg_valid = 1'b0;
      cfg_mode  = 1'b0;
      n_cmp++;
      if (cfg_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL toggle_ready_pending: got %b want 0", cfg_ready);
      end
      step();                       // wrap, apply, clk_en restarts low
      n_cmp++;
      if (cfg_ready !== 1'b1 || clk_en !== 4'b0000) begin
         n_bad++;
         $display("FAIL toggle_apply: got ready=%b clk_en=%b want ready=1 clk_en=0000",
                  cfg_ready, clk_en);
      end
      for (int k = 1; k <= 15; k++) begin
         step();
         exp = ((k / 5) % 2 == 1) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if (clk_en !== exp) begin
            n_bad++;
            $display("FAIL toggle_div5 k%0d: got %b want %b", k, clk_en, exp);
         end
      end
   endtask

   // ch0 at div 8; request div 3 at cnt 3: old period finishes, then div 3.
   task automatic test_reconfig();
      logic [3:0] exp;
      logic       exp_rdy;
      stop_all();
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_div   = 16'd8;
      cfg_mode  = 1'b0;
      step();                       // accept while stopped
      cfg_valid = 1'b0;
      step();                       // applied on the following edge
      n_cmp++;
      if (cfg_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL stopped_apply_ready: got %b want 1", cfg_ready);
      end
      ch_en = 4'b0001;
      for (int k = 0; k <= 13; k++) begin
         if (k == 3) begin
            cfg_valid = 1'b1;
            cfg_div   = 16'd3;
         end
         step();
         if (k == 3) cfg_valid = 1'b0;
         exp     = (k == 7 || k == 10 || k == 13) ? 4'b0001 : 4'b0000;
         exp_rdy = !(k >= 3 && k < 7);
         n_cmp++;
         if (clk_en !== exp || cfg_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL reconfig R%0d: got clk_en=%b ready=%b want clk_en=%b ready=%b",
                     k, clk_en, cfg_ready, exp, exp_rdy);
         end
      end
   endtask

   // cfg_div = 0 to running ch2: error pulse, divisor 2 kept.
   task automatic test_cfg_err();
      logic [3:0] exp;
      stop_all();
      ch_en = 4'b0100;
      step();
      step();
      n_cmp++;
      if (clk_en !== 4'b0100) begin
         n_bad++;
         $display("FAIL err_pre: got %b want 0100", clk_en);
      end
      cfg_valid = 1'b1;
      cfg_ch    = 2'd2;
      cfg_div   = 16'd0;
      step();
      cfg_valid = 1'b0;
      n_cmp++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || clk_en !== 4'b0000) begin
         n_bad++;
         $display("FAIL err_pulse: got err=%b ready=%b clk_en=%b want err=1 ready=1 clk_en=0000",
                  cfg_err, cfg_ready, clk_en);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         exp = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         n_cmp++;
         if (cfg_err !== 1'b0 || clk_en !== exp) begin
            n_bad++;
            $display("FAIL err_after k%0d: got err=%b clk_en=%b want err=0 clk_en=%b",
                     k, cfg_err, clk_en, exp);
         end
      end
   endtask

   // ch3 at div 4 toggle; reset mid-period, then count again from cnt 0.
   task automatic test_reset_mid();
      logic [3:0] exp;
      stop_all();
      cfg_valid = 1'b1;
      cfg_ch    = 2'd3;
      cfg_div   = 16'd4;
      cfg_mode  = 1'b1;
      step();
      cfg_valid = 1'b0;
      cfg_mode  = 1'b0;
      step();
      ch_en = 4'b1000;
      for (int k = 0; k <= 4; k++) begin
         step();
         exp = (k >= 3) ? 4'b1000 : 4'b0000;
         n_cmp++;
         if (clk_en !== exp) begin
            n_bad++;
            $display("FAIL tog4 T%0d: got %b want %b", k, clk_en, exp);
         end
      end
      #1 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (clk_en !== 4'b0000) begin
         n_bad++;
         $display("FAIL async_reset: got %b want 0000", clk_en);
      end
      step();
      reset_n = 1'b1;
      // Reset restored div 2 pulse; ch3 restarts from cnt 0.
      for (int k = 0; k < 4; k++) begin
         step();
         exp = (k % 2 == 1) ? 4'b1000 : 4'b0000;
         n_cmp++;
         if (clk_en !== exp) begin
            n_bad++;
            $display("FAIL post_reset U%0d: got %b want %b", k, clk_en, exp);
         end
      end
      // Re-program div 4 toggle: first rise on the 4th running edge.
      stop_all();
      cfg_valid = 1'b1;
      cfg_div   = 16'd4;
      cfg_mode  = 1'b1;
      step();
      cfg_valid = 1'b0;
      cfg_mode  = 1'b0;
      step();
      ch_en = 4'b1000;
      for (int k = 0; k < 8; k++) begin
         step();
         exp = (k >= 3 && k <= 6) ? 4'b1000 : 4'b0000;
         n_cmp++;
         if (clk_en !== exp) begin
            n_bad++;
            $display("FAIL post_reset_tog4 V%0d: got %b want %b", k, clk_en, exp);
         end
      end
   endtask

`ifdef CLK_EN_PHASE_EN
   // ch0 div 6 phase 4: first strobe 2 edges after start, then every 6.
   task automatic test_phase();
      logic [3:0] exp;
      stop_all();
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_div   = 16'd6;
      cfg_phase = 16'd6;
      cfg_mode  = 1'b0;
      step();
      n_cmp++;
      if (cfg_err !== 1'b1) begin
         n_bad++;
         $display("FAIL phase_reject: got %b want 1", cfg_err);
      end
      cfg_phase = 16'd4;
      step();
      cfg_valid = 1'b0;
      cfg_phase = 16'd0;
      n_cmp++;
      if (cfg_err !== 1'b0) begin
         n_bad++;
         $display("FAIL phase_accept: got %b want 0", cfg_err);
      end
      step();
      ch_en = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         step();
         exp = (k == 1 || k == 7) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (clk_en !== exp) begin
            n_bad++;
            $display("FAIL phase P%0d: got %b want %b", k, clk_en, exp);
         end
      end
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      ch_en     = 4'b0000;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_div   = 16'd0;
      cfg_mode  = 1'b0;
`ifdef CLK_EN_PHASE_EN
      cfg_phase = 16'd0;
`endif
      test_reset();
      test_default_div();
      test_toggle_cfg();
      test_reconfig();
      test_cfg_err();
      test_reset_mid();
`ifdef CLK_EN_PHASE_EN
      test_phase();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_clk_en_gen_multi
